ksa: RTL and testbench
======================

# ksa

- ARC4 key-scheduling stage.
- Sits directly downstream of the S-memory initialiser. It consumes the identity-filled 256×8 S memory, S[i]=i, and permutes it in place using a 24-bit key.
- It shares the external single-port synchronous S memory (s_mem) with the initialiser; the top level muxes memory ownership.
- Start/finish uses the same en/rdy handshake as the other stages.

## Interface
Parameters:
- KEYLEN, 3: key length in bytes. Fixed for this design.
- MEMDEPTH, 256: S memory depth. Address width is 8.

Ports:
- clk, in, 1: system clock. All state updates on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- en, in, 1: start request. Sampled only while rdy=1.
- rdy, out, 1: high when idle and able to accept en.
- key, in, 24: cipher key. Byte 0 = key[23:16], byte 1 = key[15:8], byte 2 = key[7:0]. Latched when en is accepted.
- addr, out, 8: S memory address.
- rddata, in, 8: S memory read data. Valid the cycle after the address is presented.
- wrdata, out, 8: S memory write data.
- wren, out, 1: S memory write enable.

## Operation
- Algorithm: j=0; for i=0..255 { j=(j+S[i]+keybyte[i mod 3]) mod 256; swap S[i], S[j] }.
- Reset values: state=IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0, key register=0.
- Arithmetic: i and j are 8-bit and wrap mod 256 naturally.
- Key index k cycles 0,1,2,0,…. It is a 2-bit counter reset to 0 at start, not a divider.

States:
- IDLE: rdy=1, wren=0. If en=1: latch key, clear i, j and k, go to RD_SI. If en=0: stay in IDLE.
- RD_SI: addr=i, wren=0. Go to CALC_J.
- CALC_J: si<=rddata; j<=j+rddata+keybyte[k]; wren=0. Go to RD_SJ.
- RD_SJ: addr=j (the updated value), wren=0. Go to WR_SI.
- WR_SI: addr=i, wrdata=rddata (S[j]), wren=1. Go to WR_SJ.
- WR_SJ: addr=j, wrdata=si, wren=1. Then:
  - if i==255, go to IDLE;
  - otherwise increment i, advance k (wraps 2→0), go to RD_SI.

Output timing:
- addr, wrdata and wren are combinational functions of the state and registers. They are stable for the whole cycle.

Boundary conditions:
- i==j: both writes target the same address with the same value. The memory is left unchanged. This case needs no special handling.
- en while rdy=0: ignored. Changes to the key input while busy are ignored.
- en held high continuously: a new run starts on the cycle rdy returns to 1. This is legal.
- rst_n low mid-run: immediate return to reset values. Partially permuted memory is not restored; the top level must re-run the initialiser.

## Timing
- Per iteration: 5 cycles (RD_SI, CALC_J, RD_SJ, WR_SI, WR_SJ).
- Full run: 1280 busy cycles.
- If en is accepted on edge 0, rdy=0 from cycle 1 through cycle 1280 and rdy=1 in cycle 1281.
- Exactly 512 write cycles per run, always paired: address i, then address j.
- Read latency assumed from memory: exactly 1 cycle. No wait states are supported.

## Structure
- Shared package ksa_pkg holds:
  - the state enum typedef (IDLE, RD_SI, CALC_J, RD_SJ, WR_SI, WR_SJ);
  - KEYLEN and MEMDEPTH;
  - the localparam for the final index, 8'd255.
- No sub-module. The key-byte select is a 3-way mux inside ksa.
- The memory is instantiated by the task top level, not inside ksa.

## Test plan
- Reset then idle: rst_n=0 mid-clock with no clock edge → rdy=1, wren=0, addr=0 immediately. en=0 for 10 cycles → no wren pulse.
- Key 24'h000000 on an identity memory:
  - first writes are (addr 0, data 0), (0,0), (1,1), (1,1), (2,3), (3,2);
  - the final memory matches the reference-model permutation.
- Key 24'h010203:
  - first iteration writes (addr 0, data 1) then (addr 1, data 0);
  - second iteration: j = 1 + 0 + 2 = 3, writes (addr 1, data 3) then (addr 3, data 0).
- Key 24'h1E4600 full run:
  - rdy low for exactly 1280 cycles;
  - 512 wren cycles;
  - final 256-byte memory equals the software KSA output.
- en toggled at cycle 100 of a run with a different key → ignored; the result equals the original-key result.
- rst_n pulsed low at cycle 600 → rdy=1 and wren=0 asynchronously. After re-init and a new en, the run completes correctly in 1280 cycles.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared types and constants for the ARC4 key-scheduling stage.
package ksa_pkg;

  localparam int KEYLEN   = 3;
  localparam int MEMDEPTH = 256;

  localparam logic [7:0] LAST_IDX = 8'd255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_SI  = 3'd1,
    CALC_J = 3'd2,
    RD_SJ  = 3'd3,
    WR_SI  = 3'd4,
    WR_SJ  = 3'd5
  } state_e;

endpackage

// File: rtl/ksa.sv
// ARC4 key scheduler: permutes an identity-filled 256x8 S memory in place
// using a 24-bit key, five cycles per index over a shared single-port memory.
module ksa #(
  parameter int KEYLEN   = 3,
  parameter int MEMDEPTH = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic                        rdy,
  input  logic [8*KEYLEN-1:0]         key,
  output logic [$clog2(MEMDEPTH)-1:0] addr,
  input  logic [7:0]                  rddata,
  output logic [7:0]                  wrdata,
  output logic                        wren
);
  import ksa_pkg::*;

  state_e              state_q;
  logic [7:0]          i_q;
  logic [7:0]          j_q;
  logic [1:0]          k_q;
  logic [7:0]          si_q;
  logic [8*KEYLEN-1:0] key_q;
  logic [7:0]          keybyte_s;

  // Key byte for the current index; byte 0 is the most significant.
  always_comb begin
    keybyte_s = 8'd0;
    case (k_q)
      2'd0:    keybyte_s = key_q[8*KEYLEN-1 -: 8];
      2'd1:    keybyte_s = key_q[8*KEYLEN-9 -: 8];
      default: keybyte_s = key_q[7:0];
    endcase
  end

  // Sequencer: read S[i], update j, read S[j], write both back swapped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 2'd0;
      si_q    <= 8'd0;
      key_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            key_q   <= key;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 2'd0;
            state_q <= RD_SI;
          end else begin
            state_q <= IDLE;
          end
        end
        RD_SI:  state_q <= CALC_J;
        CALC_J: begin
          si_q    <= rddata;
          j_q     <= j_q + rddata + keybyte_s;
          state_q <= RD_SJ;
        end
        RD_SJ:  state_q <= WR_SI;
        WR_SI:  state_q <= WR_SJ;
        WR_SJ: begin
          if (i_q == LAST_IDX) begin
            state_q <= IDLE;
          end else begin
            i_q     <= i_q + 8'd1;
            k_q     <= (k_q == 2'(KEYLEN - 1)) ? 2'd0 : k_q + 2'd1;
            state_q <= RD_SI;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port drive; WR_SI forwards S[j] straight from the read port.
  always_comb begin
    rdy    = 1'b0;
    addr   = i_q;
    wrdata = 8'd0;
    wren   = 1'b0;
    case (state_q)
      IDLE: begin
        rdy  = 1'b1;
        addr = 8'd0;
      end
      RD_SI:  addr = i_q;
      CALC_J: addr = i_q;
      RD_SJ:  addr = j_q;
      WR_SI: begin
        addr   = i_q;
        wrdata = rddata;
        wren   = 1'b1;
      end
      WR_SJ: begin
        addr   = j_q;
        wrdata = si_q;
        wren   = 1'b1;
      end
      default: begin
        rdy  = 1'b0;
        addr = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: synchronous memory model plus a software KSA reference.
module tb_ksa;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;
  logic        init_req;

  logic [7:0]  mem   [256];
  logic [7:0]  ref_s [256];
  logic [15:0] wlog  [$];

  int n_pass;
  int n_total;

  ksa dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  always #5 clk = ~clk;

  // Single-port synchronous S memory with one-cycle read latency, plus write log.
  always @(posedge clk) begin
    if (init_req) begin
      for (int x = 0; x < 256; x++) mem[x] <= 8'(x);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
    if (wren) wlog.push_back({addr, wrdata});
  end

  task automatic init_mem();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  task automatic ref_init();
    for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
  endtask

  // Textbook ARC4 key schedule on the reference array.
  task automatic ref_run(input logic [23:0] k);
    int j;
    int kb;
    logic [7:0] t;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       kb = int'(k[23:16]);
        1:       kb = int'(k[15:8]);
        default: kb = int'(k[7:0]);
      endcase
      j = (j + int'(ref_s[i]) + kb) % 256;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  function automatic int mem_diff();
    int d;
    d = 0;
    for (int x = 0; x < 256; x++) if (mem[x] !== ref_s[x]) d++;
    return d;
  endfunction

  // Start a run with key k; optionally poke en/key with pk for 5 cycles from busy cycle poke.
  task automatic run_ksa(input logic [23:0] k, input int poke, input logic [23:0] pk,
                         output int busy);
    @(negedge clk);
    wlog.delete();
    key = k;
    en  = 1'b1;
    @(negedge clk);
    en   = 1'b0;
    busy = 0;
    for (int c = 0; c < 2000; c++) begin
      if (rdy) break;
      busy++;
      if (poke >= 0 && busy == poke) begin
        en  = 1'b1;
        key = pk;
      end
      if (poke >= 0 && busy == poke + 5) en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int wcnt;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", rdy); else n_pass++;
    n_total++;
    if (wren !== 1'b0) $display("FAIL reset_wren: got %b want 0", wren); else n_pass++;
    n_total++;
    if (addr !== 8'd0) $display("FAIL reset_addr: got %0d want 0", addr); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    wcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wren === 1'b1) wcnt++;
    end
    n_total++;
    if (wcnt !== 0 || rdy !== 1'b1)
      $display("FAIL idle_no_write: wren cycles %0d rdy %b want 0 and 1", wcnt, rdy);
    else n_pass++;
  endtask

  task automatic test_zero_key();
    int busy;
    logic [15:0] exp_w [6];
    exp_w = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
    init_mem();
    ref_init();
    ref_run(24'h000000);
    run_ksa(24'h000000, -1, 24'h0, busy);
    for (int n = 0; n < 6; n++) begin
      n_total++;
      if (wlog.size() <= n || wlog[n] !== exp_w[n])
        $display("FAIL zero_key_write%0d: got %h want %h", n,
                 (wlog.size() > n) ? wlog[n] : 16'hxxxx, exp_w[n]);
      else n_pass++;
    end
    n_total++;
    if (mem_diff() !== 0) $display("FAIL zero_key_mem: %0d bytes differ want 0", mem_diff());
    else n_pass++;
  endtask

  task automatic test_key_010203();
    int busy;
    logic [15:0] exp_w [4];
    exp_w = '{16'h0001, 16'h0100, 16'h0103, 16'h0300};
    init_mem();
    ref_init();
    ref_run(24'h010203);
    run_ksa(24'h010203, -1, 24'h0, busy);
    for (int n = 0; n < 4; n++) begin
      n_total++;
      if (wlog.size() <= n || wlog[n] !== exp_w[n])
        $display("FAIL key010203_write%0d: got %h want %h", n,
                 (wlog.size() > n) ? wlog[n] : 16'hxxxx, exp_w[n]);
      else n_pass++;
    end
    n_total++;
    if (mem_diff() !== 0) $display("FAIL key010203_mem: %0d bytes differ want 0", mem_diff());
    else n_pass++;
  endtask

  task automatic test_full_run(input logic [23:0] k);
    int busy;
    int bad_pair;
    init_mem();
    ref_init();
    ref_run(k);
    run_ksa(k, -1, 24'h0, busy);
    n_total++;
    if (busy !== 1280) $display("FAIL full_busy(%h): got %0d want 1280", k, busy); else n_pass++;
    n_total++;
    if (wlog.size() !== 512) $display("FAIL full_writes(%h): got %0d want 512", k, wlog.size());
    else n_pass++;
    bad_pair = 0;
    for (int n = 0; n < wlog.size() / 2; n++) if (wlog[2*n][15:8] !== 8'(n)) bad_pair++;
    n_total++;
    if (bad_pair !== 0) $display("FAIL full_pairing(%h): got %0d bad want 0", k, bad_pair);
    else n_pass++;
    n_total++;
    if (mem_diff() !== 0) $display("FAIL full_mem(%h): %0d bytes differ want 0", k, mem_diff());
    else n_pass++;
  endtask

  task automatic test_en_while_busy();
    int busy;
    logic [23:0] k;
    k = 24'($urandom);
    init_mem();
    ref_init();
    ref_run(k);
    run_ksa(k, 100, ~k, busy);
    n_total++;
    if (busy !== 1280 || mem_diff() !== 0)
      $display("FAIL en_busy_ignored: busy %0d diff %0d want 1280 and 0", busy, mem_diff());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int busy1;
    int busy2;
    logic [23:0] k;
    k = 24'($urandom);
    init_mem();
    ref_init();
    ref_run(k);
    ref_run(k);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(negedge clk);
    busy1 = 0;
    for (int c = 0; c < 2000; c++) begin
      if (rdy) break;
      busy1++;
      @(negedge clk);
    end
    @(negedge clk);
    busy2 = 0;
    for (int c = 0; c < 2000; c++) begin
      if (rdy) break;
      busy2++;
      if (busy2 == 3) en = 1'b0;
      @(negedge clk);
    end
    en = 1'b0;
    n_total++;
    if (busy1 !== 1280 || busy2 !== 1280)
      $display("FAIL back_to_back_busy: got %0d/%0d want 1280/1280", busy1, busy2);
    else n_pass++;
    n_total++;
    if (mem_diff() !== 0) $display("FAIL back_to_back_mem: %0d bytes differ want 0", mem_diff());
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int busy;
    logic [23:0] k;
    k = 24'($urandom);
    init_mem();
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (599) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rdy !== 1'b1 || wren !== 1'b0)
      $display("FAIL midrun_reset: rdy %b wren %b want 1 and 0", rdy, wren);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    init_mem();
    ref_init();
    ref_run(k);
    run_ksa(k, -1, 24'h0, busy);
    n_total++;
    if (busy !== 1280 || mem_diff() !== 0)
      $display("FAIL midrun_rerun: busy %0d diff %0d want 1280 and 0", busy, mem_diff());
    else n_pass++;
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b0;
    key      = 24'h0;
    init_req = 1'b0;
    n_pass   = 0;
    n_total  = 0;
    test_reset();
    test_zero_key();
    test_key_010203();
    test_full_run(24'h1E4600);
    test_full_run(24'($urandom));
    test_en_while_busy();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
